// File: rtl/pe_issue_arbiter.sv
// Round-robin issue arbiter sharing one fixed-latency PE between NUM_REQ requesters,
// with tag tracking for in-order result return, register-file writeback and a drain handshake.
module pe_issue_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PE_LAT  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_opcode,
  input  logic [32*NUM_REQ-1:0]  req_op1,
  input  logic [32*NUM_REQ-1:0]  req_op2,
  input  logic [32*NUM_REQ-1:0]  req_op3,
  input  logic [NUM_REQ-1:0]     req_wb_en,
  input  logic [5*NUM_REQ-1:0]   req_wb_addr,
  output logic [31:0]            pe_opcode,
  output logic [31:0]            pe_op1,
  output logic [31:0]            pe_op2,
  output logic [31:0]            pe_op3,
  output logic                   pe_valid,
  input  logic [31:0]            pe_result,
  input  logic                   pe_valid_out,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err,
  output logic                   rf_wr_en,
  output logic [4:0]             rf_wr_addr,
  output logic [31:0]            rf_wr_data,
  input  logic                   drain_req,
  output logic                   drain_done,
  output logic                   busy,
  output logic                   err_missing,
  output logic                   err_spurious
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

  state_t           state, state_nxt;
  logic             grant_en;
  logic             accept;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant_id;
  logic [IDW:0]     cand;
  logic             found;

  logic [31:0]      sel_opcode, sel_op1, sel_op2, sel_op3;
  logic             sel_wb;
  logic [4:0]       sel_addr;

  // Stage 0 runs alongside pe_valid; stage PE_LAT is the result slot.
  logic             tag_v    [PE_LAT+1];
  logic [IDW-1:0]   tag_id   [PE_LAT+1];
  logic             tag_wb   [PE_LAT+1];
  logic [4:0]       tag_addr [PE_LAT+1];

  logic             slot_v;
  logic [NUM_REQ-1:0] slot_onehot;

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    found     = 1'b0;
    cand      = '0;
    if (grant_en) begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        cand = {1'b0, last_grant} + (IDW+1)'(k);
        if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
        if (!found && req_valid[cand[IDW-1:0]]) begin
          found                     = 1'b1;
          req_ready[cand[IDW-1:0]]  = 1'b1;
          grant_id                  = cand[IDW-1:0];
        end
      end
    end
  end

  assign accept = |req_ready;

  always_comb begin
    sel_opcode = '0;
    sel_op1    = '0;
    sel_op2    = '0;
    sel_op3    = '0;
    sel_wb     = 1'b0;
    sel_addr   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_opcode = req_opcode[32*i +: 32];
        sel_op1    = req_op1[32*i +: 32];
        sel_op2    = req_op2[32*i +: 32];
        sel_op3    = req_op3[32*i +: 32];
        sel_wb     = req_wb_en[i];
        sel_addr   = req_wb_addr[5*i +: 5];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pe_valid   <= 1'b0;
      pe_opcode  <= '0;
      pe_op1     <= '0;
      pe_op2     <= '0;
      pe_op3     <= '0;
      last_grant <= IDW'(NUM_REQ-1);
    end else begin
      pe_valid <= accept;
      if (accept) begin
        pe_opcode  <= sel_opcode;
        pe_op1     <= sel_op1;
        pe_op2     <= sel_op2;
        pe_op3     <= sel_op3;
        last_grant <= grant_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k <= PE_LAT; k++) begin
        tag_v[k]    <= 1'b0;
        tag_id[k]   <= '0;
        tag_wb[k]   <= 1'b0;
        tag_addr[k] <= '0;
      end
    end else begin
      tag_v[0]    <= accept;
      tag_id[0]   <= grant_id;
      tag_wb[0]   <= sel_wb;
      tag_addr[0] <= sel_addr;
      for (int unsigned k = 1; k <= PE_LAT; k++) begin
        tag_v[k]    <= tag_v[k-1];
        tag_id[k]   <= tag_id[k-1];
        tag_wb[k]   <= tag_wb[k-1];
        tag_addr[k] <= tag_addr[k-1];
      end
    end
  end

  assign slot_v = tag_v[PE_LAT];

  always_comb begin
    slot_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      slot_onehot[i] = slot_v && (tag_id[PE_LAT] == IDW'(i));
    end
  end

  always_comb begin
    busy = pe_valid;
    for (int unsigned k = 0; k <= PE_LAT; k++) begin
      busy = busy | tag_v[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      rf_wr_en     <= 1'b0;
      rf_wr_addr   <= '0;
      rf_wr_data   <= '0;
      err_missing  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rf_wr_en  <= 1'b0;
      if (slot_v) begin
        rsp_valid <= slot_onehot;
        if (pe_valid_out) begin
          rsp_data <= pe_result;
          if (tag_wb[PE_LAT]) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= tag_addr[PE_LAT];
            rf_wr_data <= pe_result;
          end
        end else begin
          rsp_err     <= 1'b1;
          err_missing <= 1'b1;
        end
      end else if (pe_valid_out) begin
        err_spurious <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant_en   = 1'b0;
    drain_done = 1'b0;
    case (state)
      RUN: begin
        if (drain_req) state_nxt = DRAIN;
        else           grant_en  = 1'b1;
      end
      DRAIN: begin
        if (!busy) state_nxt = DRAINED;
      end
      DRAINED: begin
        drain_done = 1'b1;
        if (!drain_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_pe_issue_arbiter.sv
// Scoreboard bench for pe_issue_arbiter: a behavioural adder PE, a reference arbiter model
// on the falling edge, and expected responses queued at accept and retired when due.
module tb_pe_issue_arbiter;

  localparam int NR     = 4;
  localparam int PE_LAT = 2;
  localparam logic [31:0] KILL = 32'hBAD0_0BAD;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [32*NR-1:0]  req_opcode, req_op1, req_op2, req_op3;
  logic [NR-1:0]     req_wb_en;
  logic [5*NR-1:0]   req_wb_addr;
  logic [31:0]       pe_opcode, pe_op1, pe_op2, pe_op3;
  logic              pe_valid;
  logic [31:0]       pe_result;
  logic              pe_valid_out;
  logic [NR-1:0]     rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic              rf_wr_en;
  logic [4:0]        rf_wr_addr;
  logic [31:0]       rf_wr_data;
  logic              drain_req = 1'b0;
  logic              drain_done, busy, err_missing, err_spurious;

  logic [31:0] f_opc [NR] = '{default: '0};
  logic [31:0] f_op1 [NR] = '{default: '0};
  logic [31:0] f_op2 [NR] = '{default: '0};
  logic [31:0] f_op3 [NR] = '{default: '0};
  logic        f_wb  [NR] = '{default: 1'b0};
  logic [4:0]  f_addr[NR] = '{default: '0};
  int          rem   [NR] = '{default: 0};

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_opcode[32*g +: 32] = f_opc[g];
    assign req_op1[32*g +: 32]    = f_op1[g];
    assign req_op2[32*g +: 32]    = f_op2[g];
    assign req_op3[32*g +: 32]    = f_op3[g];
    assign req_wb_en[g]           = f_wb[g];
    assign req_wb_addr[5*g +: 5]  = f_addr[g];
  end

  pe_issue_arbiter #(.NUM_REQ(NR), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2), .req_op3(req_op3),
    .req_wb_en(req_wb_en), .req_wb_addr(req_wb_addr),
    .pe_opcode(pe_opcode), .pe_op1(pe_op1), .pe_op2(pe_op2), .pe_op3(pe_op3),
    .pe_valid(pe_valid), .pe_result(pe_result), .pe_valid_out(pe_valid_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .drain_req(drain_req), .drain_done(drain_done), .busy(busy),
    .err_missing(err_missing), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PE: adds op1+op2 with PE_LAT cycles latency; ops tagged with KILL in op3 lose their result.
  logic        pv [PE_LAT] = '{default: 1'b0};
  logic [31:0] pr [PE_LAT] = '{default: '0};
  logic        spur = 1'b0;
  always @(posedge clk) begin
    pv[0] <= pe_valid && (pe_op3 != KILL);
    pr[0] <= pe_op1 + pe_op2;
    for (int k = 1; k < PE_LAT; k++) begin
      pv[k] <= pv[k-1];
      pr[k] <= pr[k-1];
    end
  end
  assign pe_valid_out = pv[PE_LAT-1] | spur;
  assign pe_result    = pr[PE_LAT-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        wb;
    logic [4:0]  addr;
    int          due;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   order_log[$];

  // Reference model state (values for the current cycle)
  int          m_state = 0;
  int          m_last  = NR-1;
  logic        m_pev   = 1'b0;
  logic [31:0] m_opc = '0, m_op1 = '0, m_op2 = '0, m_op3 = '0;
  logic        m_miss = 1'b0, m_spur = 1'b0;
  logic        mon_en = 1'b0;
  logic [NR-1:0] acc_mask = '0;

  logic [NR-1:0] exp_rdy;
  logic          mb;
  int            gid, idx;
  exp_t          e;

  always @(negedge clk) begin
    acc_mask = '0;
    if (mon_en) begin
      check("pe_valid",  pe_valid,  m_pev);
      check("pe_opcode", pe_opcode, m_opc);
      check("pe_op1",    pe_op1,    m_op1);
      check("pe_op2",    pe_op2,    m_op2);
      check("pe_op3",    pe_op3,    m_op3);

      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
        if (e.err) begin
          check("rsp_err_miss", rsp_err, 1'b1);
          check("rsp_data_miss", rsp_data, 32'h0);
          check("rf_wr_en_miss", rf_wr_en, 1'b0);
        end else begin
          check("rsp_err", rsp_err, 1'b0);
          check("rsp_data", rsp_data, e.data);
          check("rf_wr_en", rf_wr_en, e.wb);
          if (e.wb) begin
            check("rf_wr_addr", rf_wr_addr, e.addr);
            check("rf_wr_data", rf_wr_data, e.data);
          end
        end
      end else begin
        check("rsp_idle", 32'(rsp_valid), 32'h0);
        check("rf_idle", rf_wr_en, 1'b0);
      end

      mb = 1'b0;
      foreach (sb[k]) if (sb[k].due > cyc) mb = 1'b1;
      check("busy", busy, mb);
      check("drain_done", drain_done, m_state == 2);
      check("err_missing", err_missing, m_miss);
      check("err_spurious", err_spurious, m_spur);

      exp_rdy = '0;
      gid = 0;
      if (m_state == 0 && !drain_req) begin
        for (int k = 1; k <= NR; k++) begin
          idx = (m_last + k) % NR;
          if (exp_rdy == '0 && req_valid[idx]) begin
            exp_rdy[idx] = 1'b1;
            gid = idx;
          end
        end
      end
      check("req_ready", 32'(req_ready), 32'(exp_rdy));

      if (rst) begin
        m_state = 0; m_last = NR-1; sb.delete(); m_pev = 1'b0;
        m_opc = '0; m_op1 = '0; m_op2 = '0; m_op3 = '0;
        m_miss = 1'b0; m_spur = 1'b0;
      end else begin
        if (sb.size() > 0 && sb[0].due == cyc + 1) begin
          if (!pe_valid_out) begin
            sb[0].err = 1'b1;
            m_miss = 1'b1;
          end
        end else if (pe_valid_out) begin
          m_spur = 1'b1;
        end
        m_pev = 1'b0;
        if (exp_rdy != '0) begin
          sb.push_back('{id: gid, data: f_op1[gid] + f_op2[gid], wb: f_wb[gid],
                         addr: f_addr[gid], due: cyc + 2 + PE_LAT, err: 1'b0});
          m_pev = 1'b1;
          m_opc = f_opc[gid]; m_op1 = f_op1[gid]; m_op2 = f_op2[gid]; m_op3 = f_op3[gid];
          m_last = gid;
          acc_mask = exp_rdy;
          order_log.push_back(gid);
        end
        case (m_state)
          0: if (drain_req) m_state = 1;
          1: if (!mb) m_state = 2;
          default: if (!drain_req) m_state = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc_mask[i]) begin
        rem[i]--;
        f_op1[i] = f_op1[i] + 3;
        if (rem[i] <= 0) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic post(input int i, input int n, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic wb, input logic [4:0] ad);
    f_opc[i]  = 32'h0210_0000 | 32'(i);
    f_op1[i]  = a;
    f_op2[i]  = b;
    f_op3[i]  = c;
    f_wb[i]   = wb;
    f_addr[i] = ad;
    rem[i]    = n;
    req_valid[i] = 1'b1;
  endtask

  task automatic settle(input int maxc);
    int k = 0;
    while ((req_valid != '0 || sb.size() != 0) && k < maxc) begin
      tick();
      k++;
    end
    check("settle", 32'((req_valid == '0) && (sb.size() == 0)), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rf_addr", 32'(rf_wr_addr), 32'h0);
    check("rst_rf_data", rf_wr_data, 32'h0);

    // fairness from a fresh reset
    order_log.delete();
    for (int i = 0; i < NR; i++) post(i, 2, 32'(100*i), 32'd7, 32'(i), (i % 2) == 1, 5'(i + 8));
    settle(40);
    check("order_len", 32'(order_log.size()), 32'd8);
    for (int k = 0; k < order_log.size() && k < 8; k++) check("order", 32'(order_log[k]), 32'(k % NR));

    // single op, then writeback
    post(0, 1, 32'd10, 32'd20, 32'd0, 1'b0, 5'd0);
    settle(20);
    post(2, 1, 32'd15, 32'd25, 32'd0, 1'b1, 5'd5);
    settle(20);

    // drain with three ops in flight
    post(0, 1, 32'd1, 32'd2, 32'd0, 1'b1, 5'd1);
    post(1, 1, 32'd3, 32'd4, 32'd0, 1'b0, 5'd2);
    post(2, 1, 32'd5, 32'd6, 32'd0, 1'b1, 5'd3);
    for (int k = 0; k < 10 && req_valid != '0; k++) tick();
    drain_req = 1'b1;
    post(3, 1, 32'd70, 32'd80, 32'd0, 1'b1, 5'd4);
    for (int k = 0; k < 20 && !drain_done; k++) tick();
    check("drain_reached", drain_done, 1'b1);
    check("drain_req3_held", req_valid[3], 1'b1);
    drain_req = 1'b0;
    settle(20);

    // missing result
    post(1, 1, 32'd5, 32'd6, KILL, 1'b1, 5'd9);
    settle(20);
    check("err_missing_sticky", err_missing, 1'b1);

    // spurious result while idle
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    tick();
    check("err_spurious_sticky", err_spurious, 1'b1);

    // reset with ops in flight
    post(0, 2, 32'd11, 32'd12, 32'd0, 1'b1, 5'd6);
    post(3, 1, 32'd13, 32'd14, 32'd0, 1'b1, 5'd7);
    tick();
    tick();
    rst = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NR; i++) rem[i] = 0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_rsp_data", rsp_data, 32'h0);
    check("mid_rst_rf_en", rf_wr_en, 1'b0);
    check("mid_rst_rf_addr", 32'(rf_wr_addr), 32'h0);
    check("mid_rst_rf_data", rf_wr_data, 32'h0);
    check("mid_rst_pe_valid", pe_valid, 1'b0);
    check("mid_rst_err_missing", err_missing, 1'b0);
    repeat (4) tick();
    post(2, 1, 32'd40, 32'd2, 32'd0, 1'b1, 5'd10);
    settle(20);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
